// File: rtl/pwd_lock_pkg.sv
// ----------------------------------------------------------------------------
// pwd_lock_pkg
// Shared definitions for the password lock sequencer:
//   - state_e   : FSM state encoding (also exported on state_o)
//   - DIGIT_W   : width of one keypad digit
//   - timer_width() : down-counter width large enough for the longest timed state
// ----------------------------------------------------------------------------
package pwd_lock_pkg;

   localparam int DIGIT_W = 4;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ENTRY   = 3'd1,
      ST_CHECK   = 3'd2,
      ST_OPEN    = 3'd3,
      ST_SET     = 3'd4,
      ST_ERROR   = 3'd5,
      ST_LOCKOUT = 3'd6
   } state_e;

   // Bits needed to hold the largest of the three cycle counts.
   function automatic int timer_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return (m < 1) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/pwd_timer.sv
// ----------------------------------------------------------------------------
// pwd_timer
// Shared down-counter for the timed states (OPEN, ERROR, LOCKOUT).
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : load strobe, takes priority over counting
//   load_val    : value loaded on load
//   expire      : high while the count equals 1 (last cycle of a timed state)
// The counter stops at zero and never wraps.
// ----------------------------------------------------------------------------
module pwd_timer #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         expire
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire = (cnt_q == W'(1));

endmodule

// File: rtl/pwd_lock_ctrl.sv
// ----------------------------------------------------------------------------
// pwd_lock_ctrl
// Central sequencer of the password lock. Collects PW_LEN digits from key
// pulses, compares against the stored password, and drives unlock / alarm /
// lockout. While open, the password can be changed.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   digit_pulse    : one-cycle digit key pulse, digit_val valid with it
//   enter_pulse    : confirm;  clear_pulse : cancel;  set_pulse : change pwd
//   unlock         : lock open (OPEN state)
//   alarm          : ERROR or LOCKOUT state
//   locked         : LOCKOUT state
//   set_done       : one-cycle pulse after a new password is stored
//   digit_cnt      : digits collected so far
//   state_o        : current state encoding
// Build option: define PWD_LOCKOUT_EN to enable the LOCKOUT state after
// MAX_FAIL consecutive failures; otherwise locked is tied low.
// Pulse priority: clear > enter > set > digit.
// ----------------------------------------------------------------------------
module pwd_lock_ctrl
   import pwd_lock_pkg::*;
#(
   parameter int                  PW_LEN      = 4,
   parameter logic [PW_LEN*4-1:0] DEFAULT_PW  = 16'h1234,
   parameter int                  OPEN_CYCLES = 8,
   parameter int                  ERR_CYCLES  = 4,
   parameter int                  LOCK_CYCLES = 16,
   parameter int                  MAX_FAIL    = 3
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          digit_pulse,
   input  logic [3:0]                    digit_val,
   input  logic                          enter_pulse,
   input  logic                          clear_pulse,
   input  logic                          set_pulse,
   output logic                          unlock,
   output logic                          alarm,
   output logic                          locked,
   output logic                          set_done,
   output logic [$clog2(PW_LEN+1)-1:0]   digit_cnt,
   output logic [2:0]                    state_o
);

   localparam int CW = $clog2(PW_LEN + 1);
   localparam int FW = $clog2(MAX_FAIL + 1);
   localparam int BW = PW_LEN * DIGIT_W;
   localparam int TW = timer_width(OPEN_CYCLES, ERR_CYCLES, LOCK_CYCLES);

   localparam logic [TW-1:0] OPEN_LD = TW'(OPEN_CYCLES);
   localparam logic [TW-1:0] ERR_LD  = TW'(ERR_CYCLES);
`ifdef PWD_LOCKOUT_EN
   localparam logic [TW-1:0] LOCK_LD = TW'(LOCK_CYCLES);
`endif

   state_e          state_q, state_d;
   logic [BW-1:0]   buf_q, buf_d;
   logic [BW-1:0]   pw_q, pw_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [FW-1:0]   fail_q, fail_d;
   logic            ovf_q, ovf_d;
   logic            set_done_q, set_done_d;
   logic            tmr_load;
   logic [TW-1:0]   tmr_val;
   logic            tmr_expire;

   // Resolve simultaneous pulses down to at most one command.
   logic clr, ent, st, dig;
   assign clr = clear_pulse;
   assign ent = enter_pulse & ~clear_pulse;
   assign st  = set_pulse & ~enter_pulse & ~clear_pulse;
   assign dig = digit_pulse & ~set_pulse & ~enter_pulse & ~clear_pulse;

   pwd_timer #(.W(TW)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .expire   (tmr_expire)
   );

   // State register and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         buf_q      <= '0;
         pw_q       <= DEFAULT_PW;
         cnt_q      <= '0;
         fail_q     <= '0;
         ovf_q      <= 1'b0;
         set_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         buf_q      <= buf_d;
         pw_q       <= pw_d;
         cnt_q      <= cnt_d;
         fail_q     <= fail_d;
         ovf_q      <= ovf_d;
         set_done_q <= set_done_d;
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_d    = state_q;
      buf_d      = buf_q;
      pw_d       = pw_q;
      cnt_d      = cnt_q;
      fail_d     = fail_q;
      ovf_d      = ovf_q;
      set_done_d = 1'b0;
      tmr_load   = 1'b0;
      tmr_val    = '0;

      case (state_q)
         ST_IDLE: begin
            // Buffer is always zero here, so only digit 0 needs writing.
            if (dig) begin
               buf_d[BW-1 -: DIGIT_W] = digit_val;
               cnt_d   = CW'(1);
               state_d = ST_ENTRY;
            end
         end

         ST_ENTRY, ST_SET: begin
            if (clr) begin
               buf_d   = '0;
               cnt_d   = '0;
               ovf_d   = 1'b0;
               state_d = ST_IDLE;
            end else if (ent) begin
               if (state_q == ST_ENTRY) begin
                  state_d = ST_CHECK;
               end else begin
                  buf_d = '0;
                  cnt_d = '0;
                  ovf_d = 1'b0;
                  if ((cnt_q == CW'(PW_LEN)) && !ovf_q) begin
                     pw_d       = buf_q;
                     set_done_d = 1'b1;
                     state_d    = ST_IDLE;
                  end else begin
                     tmr_load = 1'b1;
                     tmr_val  = ERR_LD;
                     state_d  = ST_ERROR;
                  end
               end
            end else if (dig) begin
               if (cnt_q < CW'(PW_LEN)) begin
                  for (int i = 0; i < PW_LEN; i++) begin
                     if (cnt_q == CW'(i)) begin
                        buf_d[(PW_LEN-1-i)*DIGIT_W +: DIGIT_W] = digit_val;
                     end
                  end
                  cnt_d = cnt_q + CW'(1);
               end else begin
                  ovf_d = 1'b1;
               end
            end
         end

         ST_CHECK: begin
            buf_d    = '0;
            cnt_d    = '0;
            ovf_d    = 1'b0;
            tmr_load = 1'b1;
            if ((cnt_q == CW'(PW_LEN)) && !ovf_q && (buf_q == pw_q)) begin
               fail_d  = '0;
               tmr_val = OPEN_LD;
               state_d = ST_OPEN;
            end else begin
               if (fail_q != FW'(MAX_FAIL)) begin
                  fail_d = fail_q + FW'(1);
               end
`ifdef PWD_LOCKOUT_EN
               if (fail_q == FW'(MAX_FAIL - 1)) begin
                  tmr_val = LOCK_LD;
                  state_d = ST_LOCKOUT;
               end else
`endif
               begin
                  tmr_val = ERR_LD;
                  state_d = ST_ERROR;
               end
            end
         end

         ST_OPEN: begin
            if (clr) begin
               state_d = ST_IDLE;
            end else if (st) begin
               state_d = ST_SET;
            end else if (tmr_expire) begin
               state_d = ST_IDLE;
            end
         end

         ST_ERROR: begin
            if (tmr_expire) begin
               state_d = ST_IDLE;
            end
         end

         ST_LOCKOUT: begin
            if (tmr_expire) begin
               fail_d  = '0;
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Moore outputs decoded from the state register.
   always_comb begin
      unlock    = (state_q == ST_OPEN);
      alarm     = (state_q == ST_ERROR) || (state_q == ST_LOCKOUT);
`ifdef PWD_LOCKOUT_EN
      locked    = (state_q == ST_LOCKOUT);
`else
      locked    = 1'b0;
`endif
      set_done  = set_done_q;
      digit_cnt = cnt_q;
      state_o   = state_q;
   end

endmodule

// File: tb/tb_pwd_lock_ctrl.sv
// Scoreboard bench for pwd_lock_ctrl. Stimulus pushes expected output
// episodes {outputs, first cycle, length}; the monitor times each episode
// of unlock/alarm/locked/set_done activity and compares against the queue.
module tb_pwd_lock_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       digit_pulse, enter_pulse, clear_pulse, set_pulse;
   logic [3:0] digit_val;
   logic       unlock, alarm, locked, set_done;
   logic [2:0] digit_cnt;
   logic [2:0] state_o;

   int unsigned cyc = 0;
   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [3:0]  o;      // {unlock, alarm, locked, set_done}
      logic [31:0] st;
      logic [31:0] len;
   } ev_t;

   ev_t exp_q[$];

   localparam logic [3:0] O_UNLOCK = 4'b1000;
   localparam logic [3:0] O_ALARM  = 4'b0100;
   localparam logic [3:0] O_LOCK   = 4'b0110;
   localparam logic [3:0] O_SETD   = 4'b0001;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pwd_lock_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .digit_pulse (digit_pulse),
      .digit_val   (digit_val),
      .enter_pulse (enter_pulse),
      .clear_pulse (clear_pulse),
      .set_pulse   (set_pulse),
      .unlock      (unlock),
      .alarm       (alarm),
      .locked      (locked),
      .set_done    (set_done),
      .digit_cnt   (digit_cnt),
      .state_o     (state_o)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: one episode = a run of identical non-zero output vectors.
   logic [3:0]  mon_o, mon_cur;
   logic        mon_act = 1'b0;
   int unsigned mon_st, mon_len;
   ev_t         mon_e;

   always @(negedge clk) begin
      mon_o = {unlock, alarm, locked, set_done};
      if (mon_act && mon_o != mon_cur) begin
         mon_act = 1'b0;
         if (exp_q.size() == 0) begin
            chk("unexpected_event", {28'd0, mon_cur}, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("ev_outputs", {28'd0, mon_cur}, {28'd0, mon_e.o});
            chk("ev_start",   mon_st,  mon_e.st);
            chk("ev_length",  mon_len, mon_e.len);
         end
      end
      if (!mon_act && mon_o != 4'b0000) begin
         mon_act = 1'b1;
         mon_cur = mon_o;
         mon_st  = cyc;
         mon_len = 0;
      end
      if (mon_act) mon_len++;
   end

   task automatic push(input logic [3:0] o, input int unsigned st, input int unsigned len);
      ev_t e;
      e.o = o; e.st = st; e.len = len;
      exp_q.push_back(e);
   endtask

   // Drive one cycle of pulses at the negedge; ed = edge number that samples them.
   task automatic press(input logic d, input logic [3:0] v, input logic e,
                        input logic c, input logic s, output int unsigned ed);
      digit_pulse = d; digit_val = v; enter_pulse = e; clear_pulse = c; set_pulse = s;
      ed = cyc + 1;
      @(negedge clk);
      digit_pulse = 1'b0; digit_val = 4'd0; enter_pulse = 1'b0;
      clear_pulse = 1'b0; set_pulse = 1'b0;
   endtask

   task automatic key(input logic [3:0] v);
      int unsigned ed;
      press(1'b1, v, 1'b0, 1'b0, 1'b0, ed);
   endtask

   task automatic enter(output int unsigned ed);
      press(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, ed);
   endtask

   task automatic code(input logic [15:0] c, input int n);
      for (int i = 0; i < n; i++) key(c[15-4*i -: 4]);
   endtask

   task automatic ticks(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expected=finish actual=timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned k, s;
      rst_n = 1'b0;
      digit_pulse = 1'b0; digit_val = 4'd0; enter_pulse = 1'b0;
      clear_pulse = 1'b0; set_pulse = 1'b0;
      ticks(3);
      chk("rst_unlock",   unlock,   0);
      chk("rst_alarm",    alarm,    0);
      chk("rst_locked",   locked,   0);
      chk("rst_set_done", set_done, 0);
      chk("rst_cnt",      digit_cnt, 0);
      chk("rst_state",    state_o,  0);
      rst_n = 1'b1;
      ticks(2);

      // Correct default code opens for 8 cycles, starting 2 cycles after enter.
      code(16'h1234, 4);
      chk("cnt_after_4", digit_cnt, 4);
      chk("state_entry", state_o, 1);
      enter(k);
      push(O_UNLOCK, k + 1, 8);
      ticks(12);
      chk("idle_after_open", state_o, 0);

      // Wrong last digit -> 4-cycle alarm.
      code(16'h1235, 4);
      enter(k);
      push(O_ALARM, k + 1, 4);
      ticks(8);
      chk("idle_after_err", state_o, 0);

      // Overflow: fifth digit dropped but sticky.
      code(16'h1234, 4);
      key(4'd9);
      chk("cnt_overflow", digit_cnt, 4);
      enter(k);
      push(O_ALARM, k + 1, 4);
      ticks(8);

      // Correct code clears the failure count before the next mistake.
      code(16'h1234, 4);
      enter(k);
      push(O_UNLOCK, k + 1, 8);
      ticks(12);

      // Short code.
      code(16'h1234, 3);
      enter(k);
      push(O_ALARM, k + 1, 4);
      ticks(8);

      // Clear beats a simultaneous digit.
      code(16'h1234, 2);
      chk("cnt_before_clr", digit_cnt, 2);
      press(1'b1, 4'd5, 1'b0, 1'b1, 1'b0, k);
      chk("clr_cnt", digit_cnt, 0);
      chk("clr_state", state_o, 0);
      ticks(2);

      // Change password to 9876 while open.
      code(16'h1234, 4);
      enter(k);
      ticks(2);
      press(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, s);
      push(O_UNLOCK, k + 1, s - (k + 1));
      chk("state_set", state_o, 4);
      code(16'h9876, 4);
      enter(k);
      push(O_SETD, k, 1);
      chk("idle_after_set", state_o, 0);
      ticks(3);
      code(16'h1234, 4);
      enter(k);
      push(O_ALARM, k + 1, 4);
      ticks(8);
      code(16'h9876, 4);
      enter(k);
      push(O_UNLOCK, k + 1, 8);
      ticks(12);

      // Three wrong codes in a row.
      for (int n = 0; n < 2; n++) begin
         code(16'h1111, 4);
         enter(k);
         push(O_ALARM, k + 1, 4);
         ticks(8);
      end
      code(16'h1111, 4);
      enter(k);
`ifdef PWD_LOCKOUT_EN
      push(O_LOCK, k + 1, 16);
      ticks(2);
      code(16'h9876, 4);
      enter(s);
      chk("lock_cnt", digit_cnt, 0);
      chk("lock_state", state_o, 6);
      ticks(16);
`else
      push(O_ALARM, k + 1, 4);
      ticks(8);
`endif
      chk("idle_after_fails", state_o, 0);
      code(16'h9876, 4);
      enter(k);
      push(O_UNLOCK, k + 1, 2);
      ticks(2);

      // Reset while open: unlock drops at once, password reverts.
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_unlock", unlock, 0);
      chk("rst_mid_state", state_o, 0);
      @(negedge clk);
      rst_n = 1'b1;
      ticks(2);
      code(16'h1234, 4);
      enter(k);
      push(O_UNLOCK, k + 1, 8);
      ticks(12);
      code(16'h9876, 4);
      enter(k);
      push(O_ALARM, k + 1, 4);

      for (int w = 0; w < 100; w++) begin
         if (exp_q.size() == 0 && !mon_act) break;
         @(negedge clk);
      end
      chk("queue_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
